// File: rtl/sync_step_worker.sv
// Step worker: on each rdy rising edge, issues num_nodes node requests
// tagged with the latched step number, then reports finished or halted.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   rdy              step release; a rising edge starts one step
//   l_step           step number, sampled on the rdy rising edge
//   num_nodes        frontier size, sampled on the rdy rising edge
//   req_ready        downstream accepts the current request
//   req_valid        node request valid (ISSUE state only)
//   node_idx         frontier index being requested
//   step_out         latched step number for the requests
//   finished         step complete (also high once halted)
//   halted           step limit reached; idle until rst
//   err              sticky: start event seen while issuing
module sync_step_worker #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 16,
    parameter int max_steps  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [DATA_WIDTH-1:0] l_step,
    input  logic [IDX_WIDTH-1:0]  num_nodes,
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [IDX_WIDTH-1:0]  node_idx,
    output logic [DATA_WIDTH-1:0] step_out,
    output logic                  finished,
    output logic                  halted,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FIN,
        S_HALT
    } state_t;

    localparam logic [DATA_WIDTH-1:0] STEP_LIMIT = DATA_WIDTH'(max_steps);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE    = IDX_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [IDX_WIDTH-1:0]  num_q, num_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic                  err_q, err_d;

    logic start;
    logic hs;
    logic last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            idx_q   <= '0;
            num_q   <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy;
        idx_d   = idx_q;
        num_d   = num_q;
        step_d  = step_q;
        err_d   = err_q;

        start = rdy & ~rdy_q;
        hs    = (state_q == S_ISSUE) & req_ready;
        // Compare against num-1 so an all-ones count ends at all-ones-minus-one.
        last  = (idx_q == (num_q - IDX_ONE));

        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    step_d = l_step;
                    num_d  = num_nodes;
                    idx_d  = '0;
                    if (l_step >= STEP_LIMIT) begin
                        state_d = S_HALT;
                    end else if (num_nodes == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A second release mid-step is a controller protocol error.
                if (start) begin
                    err_d = 1'b1;
                end
                if (hs) begin
                    if (last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign req_valid = (state_q == S_ISSUE);
    assign finished  = (state_q == S_FIN) | (state_q == S_HALT);
    assign halted    = (state_q == S_HALT);
    assign node_idx  = idx_q;
    assign step_out  = step_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sync_step_worker.sv
// Testbench for sync_step_worker: vector table plus directed
// multi-cycle sequences with handshake counting.
module tb_sync_step_worker;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] l_step;
    logic [15:0] num_nodes;
    logic        req_ready;
    logic        req_valid;
    logic [15:0] node_idx;
    logic [31:0] step_out;
    logic        finished;
    logic        halted;
    logic        err;

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int seen_valid;

    always #5 clk = ~clk;

    sync_step_worker dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .l_step    (l_step),
        .num_nodes (num_nodes),
        .req_ready (req_ready),
        .req_valid (req_valid),
        .node_idx  (node_idx),
        .step_out  (step_out),
        .finished  (finished),
        .halted    (halted),
        .err       (err)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] l_step;
        logic [15:0] num;
        logic        rr;
        logic        e_rv;
        logic [15:0] e_idx;
        logic [31:0] e_step;
        logic        e_fin;
        logic        e_halt;
        logic        e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: count a handshake presented before the edge, then
    // move to 1ns after the edge where outputs are checked.
    task automatic cyc();
        if (req_valid === 1'b1 && req_ready === 1'b1 && rst === 1'b0)
            hs++;
        if (req_valid === 1'b1)
            seen_valid++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rdy       = 1'b0;
        l_step    = '0;
        num_nodes = '0;
        req_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        hs  = 0;
    endtask

    task automatic wait_fin(input string name);
        for (int k = 0; k < 20 && finished !== 1'b1; k++)
            cyc();
        chk(name, {31'd0, finished}, 32'd1);
    endtask

    initial begin
        //          rst rdy l_step num rr  rv idx step fin hlt err
        tbl[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 4, 1,   1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 9, 1,   1, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 9, 1,   1, 2, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 9, 1,   1, 3, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 9, 1,   0, 3, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, 0, 9, 1,   0, 3, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 2, 0, 1,   0, 3, 0, 1, 0, 0};
        tbl[9]  = '{0, 1, 2, 0, 1,   0, 0, 2, 1, 0, 0};
        tbl[10] = '{0, 0, 3, 1, 0,   0, 0, 2, 1, 0, 0};
        tbl[11] = '{0, 1, 3, 1, 0,   1, 0, 3, 0, 0, 0};
        tbl[12] = '{0, 1, 3, 1, 0,   1, 0, 3, 0, 0, 0};
        tbl[13] = '{0, 1, 3, 1, 1,   0, 0, 3, 1, 0, 0};

        rst = 1'b1; rdy = 1'b0; l_step = '0; num_nodes = '0; req_ready = 1'b0;
        #1;

        for (int i = 0; i < 14; i++) begin
            rst       = tbl[i].rst;
            rdy       = tbl[i].rdy;
            l_step    = tbl[i].l_step;
            num_nodes = tbl[i].num;
            req_ready = tbl[i].rr;
            cyc();
            chk($sformatf("v%0d.req_valid", i), {31'd0, req_valid}, {31'd0, tbl[i].e_rv});
            chk($sformatf("v%0d.node_idx", i), {16'd0, node_idx}, {16'd0, tbl[i].e_idx});
            chk($sformatf("v%0d.step_out", i), step_out, tbl[i].e_step);
            chk($sformatf("v%0d.finished", i), {31'd0, finished}, {31'd0, tbl[i].e_fin});
            chk($sformatf("v%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halt});
            chk($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
        end

        // Backpressure: ready toggles 1,0,1,0,1 with three nodes.
        do_reset();
        rdy = 1'b1; l_step = 32'd1; num_nodes = 16'd3; req_ready = 1'b0;
        cyc();
        req_ready = 1'b1; cyc();
        chk("bp.idx_after_hs1", {16'd0, node_idx}, 32'd1);
        req_ready = 1'b0; cyc();
        chk("bp.idx_hold", {16'd0, node_idx}, 32'd1);
        req_ready = 1'b1; cyc();
        chk("bp.idx_after_hs2", {16'd0, node_idx}, 32'd2);
        req_ready = 1'b0; cyc();
        chk("bp.idx_hold2", {16'd0, node_idx}, 32'd2);
        chk("bp.not_fin", {31'd0, finished}, 32'd0);
        req_ready = 1'b1; cyc();
        chk("bp.fin", {31'd0, finished}, 32'd1);
        chk("bp.rv_low", {31'd0, req_valid}, 32'd0);
        chk("bp.hs", hs, 32'd3);

        // Seven steps of two nodes, then the step limit.
        do_reset();
        req_ready = 1'b1;
        for (int s = 0; s < 7; s++) begin
            rdy = 1'b0; cyc();
            rdy = 1'b1; l_step = s; num_nodes = 16'd2; cyc();
            chk($sformatf("lim.step%0d_out", s), step_out, s);
            wait_fin($sformatf("lim.step%0d_fin", s));
        end
        chk("lim.hs14", hs, 32'd14);
        rdy = 1'b0; cyc();
        rdy = 1'b1; l_step = 32'd7; num_nodes = 16'd3; cyc();
        chk("lim.halted", {31'd0, halted}, 32'd1);
        chk("lim.finished", {31'd0, finished}, 32'd1);
        chk("lim.rv", {31'd0, req_valid}, 32'd0);
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            rdy = 1'b0; l_step = 32'd1; cyc();
            rdy = 1'b1; cyc();
        end
        cyc();
        chk("lim.no_req_after_halt", seen_valid, 32'd0);
        chk("lim.hs_unchanged", hs, 32'd14);
        chk("lim.still_halted", {31'd0, halted}, 32'd1);

        // Second release during a step flags err but does not disturb it.
        do_reset();
        rdy = 1'b1; l_step = '0; num_nodes = 16'd5; req_ready = 1'b0;
        cyc();
        rdy = 1'b0; cyc();
        chk("err.clear_before", {31'd0, err}, 32'd0);
        rdy = 1'b1; num_nodes = 16'd2; cyc();
        chk("err.set", {31'd0, err}, 32'd1);
        chk("err.still_issue", {31'd0, req_valid}, 32'd1);
        chk("err.idx0", {16'd0, node_idx}, 32'd0);
        req_ready = 1'b1;
        wait_fin("err.fin");
        chk("err.hs5", hs, 32'd5);
        chk("err.sticky", {31'd0, err}, 32'd1);

        // Reset mid-step; rdy held high through release restarts a step.
        do_reset();
        rdy = 1'b1; l_step = 32'd4; num_nodes = 16'd6; req_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rst.hs2", hs, 32'd2);
        rst = 1'b1; cyc();
        chk("rst.rv", {31'd0, req_valid}, 32'd0);
        chk("rst.fin", {31'd0, finished}, 32'd0);
        chk("rst.idx", {16'd0, node_idx}, 32'd0);
        chk("rst.step", step_out, 32'd0);
        chk("rst.hs_frozen", hs, 32'd2);
        rst = 1'b0; l_step = 32'd5; num_nodes = 16'd1; cyc();
        chk("rst.restart_rv", {31'd0, req_valid}, 32'd1);
        chk("rst.restart_step", step_out, 32'd5);
        cyc();
        chk("rst.restart_fin", {31'd0, finished}, 32'd1);
        chk("rst.hs_total", hs, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_step_worker.md
SYNC_STEP_WORKER -- requirements
Module: sync_step_worker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of l_step and step_out.
REQ-002 Parameter IDX_WIDTH, default 16: width of num_nodes and node_idx.
REQ-003 Parameter max_steps, default 7: first step number the worker refuses to execute.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 rdy  in  1: step-release from the dual step controller; a rising edge starts one step.
REQ-007 l_step  in  DATA_WIDTH: current step number from the controller, sampled on the rdy rising edge.
REQ-008 num_nodes  in  IDX_WIDTH: frontier size for this step, sampled on the rdy rising edge.
REQ-009 req_ready  in  1: downstream diffusion datapath accepts the current request.
REQ-010 req_valid  out  1: node request valid.
REQ-011 node_idx  out  IDX_WIDTH: frontier index being requested.
REQ-012 step_out  out  DATA_WIDTH: latched step number accompanying each request.
REQ-013 finished  out  1: step complete; drives the controller's finished1/finished2 input.
REQ-014 halted  out  1: step limit reached; worker is idle until rst.
REQ-015 err  out  1: sticky protocol-error flag.

Function
REQ-016 The worker SHALL implement states IDLE, ISSUE, FIN, HALT.
REQ-017 The worker SHALL register rdy each cycle (rdy_q); a start event SHALL be rdy=1 and rdy_q=0.
REQ-018 On a start event in IDLE or FIN, the worker SHALL latch l_step into step_out, latch num_nodes, clear node_idx to 0, and deassert finished on the next edge.
REQ-019 On that start event, if l_step >= max_steps, the next state SHALL be HALT; else if num_nodes == 0, FIN; else ISSUE.
REQ-020 In ISSUE, req_valid SHALL be 1 and node_idx, step_out SHALL hold stable until req_valid & req_ready.
REQ-021 On handshake in ISSUE with node_idx < latched num_nodes-1, node_idx SHALL increment by 1 and the state SHALL remain ISSUE (back-to-back, one request per cycle when req_ready is held high).
REQ-022 On handshake in ISSUE with node_idx == latched num_nodes-1, the next state SHALL be FIN with req_valid=0 and finished=1 on the following cycle.
REQ-023 Exactly latched num_nodes handshakes SHALL occur per executed step; num_nodes changes after the start event SHALL have no effect.
REQ-024 In FIN, finished SHALL remain 1 until the next start event; rdy level alone (without an edge) SHALL not restart a step.
REQ-025 In HALT, req_valid SHALL be 0, finished SHALL be 1, halted SHALL be 1, and all start events SHALL be ignored until rst.
REQ-026 A start event while in ISSUE SHALL be ignored for sequencing and SHALL set err to 1; err SHALL hold until rst.
REQ-027 req_valid SHALL never be asserted in IDLE, FIN, or HALT.
REQ-028 node_idx arithmetic SHALL be modulo 2^IDX_WIDTH; num_nodes = 2^IDX_WIDTH-1 SHALL issue indices 0 through 2^IDX_WIDTH-2 without wrap.

Reset
REQ-029 While rst=1, state SHALL be IDLE and req_valid=0, node_idx=0, step_out=0, finished=0, halted=0, err=0, rdy_q=0.
REQ-030 rst asserted mid-ISSUE SHALL abort the step on the same edge with no further handshakes; a rdy held high through reset release SHALL count as a start event on the first cycle after release.

Verification
REQ-031 rst, then rdy 0->1 with l_step=0, num_nodes=4, req_ready=1 -> req_valid for 4 cycles, node_idx 0,1,2,3, step_out=0, then finished=1.
REQ-032 num_nodes=3, req_ready toggling 1,0,1,0,1 -> node_idx holds during req_ready=0, exactly 3 handshakes, finished=1 the cycle after the third handshake.
REQ-033 rdy edge with num_nodes=0, l_step=2 -> no req_valid, finished=1 one cycle after the edge, step_out=2.
REQ-034 Steps l_step=0..6 each with num_nodes=2, then rdy edge with l_step=7 -> 14 total handshakes, then halted=1, finished=1, further rdy edges produce no requests.
REQ-035 rdy falls and rises again during ISSUE (num_nodes=5) -> err=1, the step still completes with 5 handshakes.
REQ-036 rst pulsed after 2 of 6 handshakes -> req_valid=0, finished=0 next cycle, all outputs at reset values.
